// File: rtl/data_memory_responder_pkg.sv
// data_memory_responder_pkg: shared memory constants, range check and saturating increment
// Provides the default bus widths plus two helpers used by the responder and its counters.
package data_memory_responder_pkg;
    localparam int MEM_DATA_WIDTH = 64;
    localparam int MEM_ADDR_WIDTH = 32;
    localparam int MEM_DEPTH_LOG2 = 8;
    localparam int MEM_CNT_WIDTH  = 16;

    // An address is in range when every bit above the index field is zero.
    function automatic logic in_range(input logic [63:0] a, input int unsigned aw, input int unsigned dl);
        logic [63:0] m;
        m = ~64'h0 >> (64 - aw);
        return ((a & m) >> dl) == 64'h0;
    endfunction

    // Increment v by one, holding at the all-ones value of a w-bit field.
    function automatic logic [63:0] sat_inc(input logic [63:0] v, input int unsigned w);
        logic [63:0] m;
        m = ~64'h0 >> (64 - w);
        return (v == m) ? v : v + 64'h1;
    endfunction
endpackage

// File: rtl/data_memory_responder_if.sv
// data_memory_responder_if: core data-memory bus between the core (master) and the responder (slave)
// Signals: mem_en, mem_wr_en, addr_in, d_in driven by the core; d_out returned by the responder.
interface data_memory_responder_if
    import data_memory_responder_pkg::*;
#(
    parameter int DATA_WIDTH = MEM_DATA_WIDTH,
    parameter int ADDR_WIDTH = MEM_ADDR_WIDTH
);
    logic                  mem_en;
    logic                  mem_wr_en;
    logic [0:ADDR_WIDTH-1] addr_in;
    logic [0:DATA_WIDTH-1] d_in;
    logic [0:DATA_WIDTH-1] d_out;

    modport master(output mem_en, mem_wr_en, addr_in, d_in, input d_out);
    modport slave(input mem_en, mem_wr_en, addr_in, d_in, output d_out);
endinterface

// File: rtl/data_memory_responder_sat_counter.sv
// sat_counter: saturating up-counter with asynchronous active-high reset
// Ports: clk, reset, inc (count enable), count (holds at all-ones).
module sat_counter
    import data_memory_responder_pkg::*;
#(
    parameter int CNT_WIDTH = MEM_CNT_WIDTH
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 inc,
    output logic [0:CNT_WIDTH-1] count
);
    always_ff @(posedge clk or posedge reset)
        if (reset) count <= '0;
        else if (inc) count <= CNT_WIDTH'(sat_inc(64'(count), CNT_WIDTH));
endmodule

// File: rtl/data_memory_responder.sv
// data_memory_responder: word-wide data memory answering the core with 1-cycle load latency
// Ports: clk, reset (async, active-high), bus (core data port, slave side),
//        preload_en/preload_addr/preload_data (backdoor write), addr_err (sticky
//        out-of-range flag), rd_count/wr_count (saturating in-range access counts).
module data_memory_responder
    import data_memory_responder_pkg::*;
#(
    parameter int DATA_WIDTH = MEM_DATA_WIDTH,
    parameter int ADDR_WIDTH = MEM_ADDR_WIDTH,
    parameter int DEPTH_LOG2 = MEM_DEPTH_LOG2,
    parameter int CNT_WIDTH  = MEM_CNT_WIDTH
) (
    input  logic                  clk,
    input  logic                  reset,
    data_memory_responder_if.slave bus,
    input  logic                  preload_en,
    input  logic [0:DEPTH_LOG2-1] preload_addr,
    input  logic [0:DATA_WIDTH-1] preload_data,
    output logic                  addr_err,
    output logic [0:CNT_WIDTH-1]  rd_count,
    output logic [0:CNT_WIDTH-1]  wr_count
);
    logic [0:DATA_WIDTH-1] mem [0:2**DEPTH_LOG2-1];
    logic [0:DEPTH_LOG2-1] idx;
    logic                  ok;
    logic                  rd;
    logic                  wr;

    assign idx = DEPTH_LOG2'(bus.addr_in);
    assign ok  = in_range(64'(bus.addr_in), ADDR_WIDTH, DEPTH_LOG2);
    assign rd  = bus.mem_en && !bus.mem_wr_en;
    assign wr  = bus.mem_en && bus.mem_wr_en;

    // The preload assignment comes last so it overrides a same-cycle core write
    // to the same index; reads always see the pre-edge contents.
    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            mem      <= '{default: '0};
            bus.d_out <= '0;
            addr_err <= 1'b0;
        end else begin
            if (rd) bus.d_out <= ok ? mem[idx] : '0;
            if (wr && ok) mem[idx] <= bus.d_in;
            if (preload_en) mem[preload_addr] <= preload_data;
            if (bus.mem_en && !ok) addr_err <= 1'b1;
        end

    sat_counter #(.CNT_WIDTH(CNT_WIDTH)) u_rd_cnt (
        .clk(clk), .reset(reset), .inc(rd && ok), .count(rd_count)
    );

    sat_counter #(.CNT_WIDTH(CNT_WIDTH)) u_wr_cnt (
        .clk(clk), .reset(reset), .inc(wr && ok), .count(wr_count)
    );
endmodule

// File: tb/tb_data_memory_responder.sv
// tb_data_memory_responder: directed and random checks of the data-memory responder against a reference model
module tb_data_memory_responder;
    logic        clk = 1'b0;
    logic        reset;
    logic        preload_en;
    logic [0:7]  preload_addr;
    logic [0:63] preload_data;
    logic        addr_err;
    logic [0:15] rd_count;
    logic [0:15] wr_count;
    logic        addr_err2;
    logic [0:2]  rd_count2;
    logic [0:2]  wr_count2;

    int n_chk = 0;
    int n_fail = 0;

    // Reference model: memory contents and visible outputs.
    logic [63:0] mm [256];
    logic [63:0] md;
    logic        me;
    logic [15:0] rc;
    logic [15:0] wc;

    data_memory_responder_if #(.DATA_WIDTH(64), .ADDR_WIDTH(32)) bus ();
    data_memory_responder_if #(.DATA_WIDTH(64), .ADDR_WIDTH(32)) bus2 ();

    data_memory_responder dut (
        .clk(clk), .reset(reset), .bus(bus),
        .preload_en(preload_en), .preload_addr(preload_addr), .preload_data(preload_data),
        .addr_err(addr_err), .rd_count(rd_count), .wr_count(wr_count)
    );

    data_memory_responder #(.CNT_WIDTH(3)) dut_small (
        .clk(clk), .reset(reset), .bus(bus2),
        .preload_en(1'b0), .preload_addr(8'h0), .preload_data(64'h0),
        .addr_err(addr_err2), .rd_count(rd_count2), .wr_count(wr_count2)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        md = '0;
        me = 1'b0;
        rc = '0;
        wc = '0;
        foreach (mm[i]) mm[i] = '0;
    endtask

    task automatic check_all();
        chk("d_out", 64'(bus.d_out), md);
        chk("addr_err", 64'(addr_err), 64'(me));
        chk("rd_count", 64'(rd_count), 64'(rc));
        chk("wr_count", 64'(wr_count), 64'(wc));
    endtask

    // One bus cycle: apply inputs, advance the model by the access rules, clock, compare.
    task automatic cycle(input logic en, input logic w, input logic [31:0] a, input logic [63:0] d,
                         input logic pe, input logic [7:0] pa, input logic [63:0] pd);
        logic inr;
        bus.mem_en = en;
        bus.mem_wr_en = w;
        bus.addr_in = a;
        bus.d_in = d;
        preload_en = pe;
        preload_addr = pa;
        preload_data = pd;
        inr = (a < 32'd256);
        if (en && !w) begin
            md = inr ? mm[a[7:0]] : 64'h0;
            if (inr && rc != 16'hFFFF) rc = rc + 16'd1;
        end
        if (en && w && inr) begin
            mm[a[7:0]] = d;
            if (wc != 16'hFFFF) wc = wc + 16'd1;
        end
        if (pe) mm[pa] = pd;
        if (en && !inr) me = 1'b1;
        @(posedge clk);
        #1;
        check_all();
    endtask

    initial begin
        logic [31:0] a;
        reset = 1'b1;
        bus.mem_en = 0; bus.mem_wr_en = 0; bus.addr_in = 0; bus.d_in = 0;
        bus2.mem_en = 0; bus2.mem_wr_en = 0; bus2.addr_in = 0; bus2.d_in = 0;
        preload_en = 0; preload_addr = 0; preload_data = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        chk("reset_d_out", 64'(bus.d_out), 64'h0);
        chk("reset_addr_err", 64'(addr_err), 64'h0);
        chk("reset_rd_count", 64'(rd_count), 64'h0);
        chk("reset_wr_count", 64'(wr_count), 64'h0);
        cycle(0, 0, 0, 0, 0, 0, 0);

        cycle(0, 0, 0, 0, 1, 8'd5, 64'hDEADBEEF_00000001);
        chk("preload_not_counted", 64'(rd_count), 64'h0);
        cycle(1, 0, 32'd5, 0, 0, 0, 0);
        chk("read5", 64'(bus.d_out), 64'hDEADBEEF_00000001);
        chk("read5_rd_count", 64'(rd_count), 64'h1);

        cycle(1, 1, 32'd3, 64'h1234, 0, 0, 0);
        chk("write_holds_d_out", 64'(bus.d_out), 64'hDEADBEEF_00000001);
        chk("write3_wr_count", 64'(wr_count), 64'h1);
        cycle(1, 0, 32'd3, 0, 0, 0, 0);
        chk("raw3", 64'(bus.d_out), 64'h1234);

        cycle(0, 0, 0, 0, 1, 8'd7, 64'h7777);
        cycle(0, 0, 0, 0, 1, 8'd9, 64'h9999);
        cycle(1, 0, 32'd7, 0, 0, 0, 0);
        chk("load7", 64'(bus.d_out), 64'h7777);
        cycle(1, 0, 32'd9, 0, 0, 0, 0);
        chk("load9", 64'(bus.d_out), 64'h9999);
        chk("load_rd_count", 64'(rd_count), 64'h4);
        cycle(0, 1, 32'd9, 64'h1, 0, 0, 0);
        chk("idle_hold9", 64'(bus.d_out), 64'h9999);

        cycle(0, 0, 0, 0, 1, 8'd0, 64'h55);
        cycle(1, 0, 32'h0000_0100, 0, 0, 0, 0);
        chk("oor_read_d_out", 64'(bus.d_out), 64'h0);
        chk("oor_addr_err", 64'(addr_err), 64'h1);
        chk("oor_rd_count", 64'(rd_count), 64'h4);
        cycle(1, 1, 32'h0001_0000, 64'hBAD, 0, 0, 0);
        chk("oor_wr_count", 64'(wr_count), 64'h1);
        cycle(1, 0, 32'd0, 0, 0, 0, 0);
        chk("oor_write_dropped", 64'(bus.d_out), 64'h55);
        chk("addr_err_sticky", 64'(addr_err), 64'h1);

        cycle(1, 1, 32'd2, 64'hBB, 1, 8'd2, 64'hAA);
        cycle(1, 0, 32'd2, 0, 1, 8'd2, 64'hCC);
        chk("preload_wins", 64'(bus.d_out), 64'hAA);
        cycle(1, 0, 32'd2, 0, 0, 0, 0);
        chk("preload_after_read", 64'(bus.d_out), 64'hCC);

        cycle(1, 0, 32'd5, 0, 0, 0, 0);
        #2 reset = 1'b1;
        #1 chk("async_reset_d_out", 64'(bus.d_out), 64'h0);
        chk("async_reset_addr_err", 64'(addr_err), 64'h0);
        model_reset();
        @(posedge clk);
        #1 reset = 1'b0;
        cycle(0, 0, 0, 0, 0, 0, 0);
        cycle(1, 0, 32'd5, 0, 0, 0, 0);
        chk("array_cleared", 64'(bus.d_out), 64'h0);

        for (int i = 0; i < 400; i++) begin
            a = ($urandom_range(0, 7) == 0) ? {$urandom_range(1, 255), 24'h0} | 32'($urandom_range(0, 255))
                                            : 32'($urandom_range(0, 15));
            cycle(1'($urandom), 1'($urandom), a, {$urandom, $urandom},
                  ($urandom_range(0, 3) == 0), 8'($urandom_range(0, 15)), {$urandom, $urandom});
        end

        bus2.mem_en = 1'b1;
        bus2.addr_in = 32'd1;
        repeat (10) @(posedge clk);
        #1 chk("rd_saturate", 64'(rd_count2), 64'h7);
        bus2.mem_wr_en = 1'b1;
        repeat (10) @(posedge clk);
        #1 chk("wr_saturate", 64'(wr_count2), 64'h7);
        chk("rd_sat_hold", 64'(rd_count2), 64'h7);
        bus2.mem_en = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/data_memory_responder.md
Name: data_memory_responder

Overview:
- Responder end of the processor's data-memory interface.
- Samples enable, write-enable, address and store data from the core, performs a word-wide read or write on an internal register array, and returns load data with a fixed 1-cycle latency.
- Adds a preload port for program/data initialisation, out-of-range detection, and access counters for verification and debug.
- Sits between the four-stage core's data port and the top-level testbench or SoC wrapper.

Parameters:
- DATA_WIDTH, 64, word width in bits; matches core data bus.
- ADDR_WIDTH, 32, width of the address port from the core.
- DEPTH_LOG2, 8, log2 of word count; the array holds 2**DEPTH_LOG2 words.
- CNT_WIDTH, 16, width of each access counter.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- mem_en  input  1  access request from the core (core memEn).
- mem_wr_en  input  1  1 = write, 0 = read; qualified by mem_en (core memWrEn).
- addr_in  input  [0:ADDR_WIDTH-1]  word address (core addr_out).
- d_in  input  [0:DATA_WIDTH-1]  store data (core d_out).
- d_out  output  [0:DATA_WIDTH-1]  load data to the core (core d_in).
- preload_en  input  1  backdoor write strobe.
- preload_addr  input  [0:DEPTH_LOG2-1]  backdoor word address.
- preload_data  input  [0:DATA_WIDTH-1]  backdoor write data.
- addr_err  output  1  sticky out-of-range flag.
- rd_count  output  [0:CNT_WIDTH-1]  accepted in-range reads.
- wr_count  output  [0:CNT_WIDTH-1]  accepted in-range writes.

Behaviour:
- Reset is asynchronous and active-high.
  - Clears d_out, addr_err, rd_count, wr_count and the whole array to 0.
  - Reset asserted mid-operation aborts any pending read; d_out = 0 on the next visible value.
- Addressing: word-addressed. In range iff addr_in[0:ADDR_WIDTH-DEPTH_LOG2-1] == 0. Index = addr_in low DEPTH_LOG2 bits.
- Read (mem_en=1, mem_wr_en=0) sampled at a rising edge:
  - d_out takes array[index] at that edge, so it is visible the following cycle (1-cycle latency).
  - The core issues a load with mem_en held for 2 consecutive cycles at the same or an updated address. Each sampled cycle re-reads.
- d_out holds its last value when mem_en=0 or on a write cycle. It never returns to 0 except on reset or an out-of-range read.
- Write (mem_en=1, mem_wr_en=1): array[index] <= d_in at the edge; d_out unchanged.
- mem_wr_en while mem_en=0 is ignored.
- Read-after-write: a read sampled one cycle after a write to the same index returns the new data. No bypass is needed because the write has already committed.
- Out-of-range access:
  - Write is dropped; read drives d_out = 0.
  - addr_err sets to 1 and stays set until reset.
  - Counters do not increment.
- Preload port:
  - When preload_en=1, array[preload_addr] <= preload_data.
  - If a core write targets the same index in the same cycle, preload wins.
  - A core read of the same index in that cycle returns the pre-edge (old) contents.
  - Preloads are not counted.
- Counters: rd_count / wr_count increment by 1 per accepted in-range access. They saturate at all-ones; no wrap.
- No stall or ready signal: every request completes in the stated time, because the core has no wait-state support.

Decomposition:
- Shared package (memory constants):
  - DATA_WIDTH and DEPTH_LOG2 defaults.
  - The in-range check as a function.
  - Saturating-increment helper.
- One natural sub-module, sat_counter (CNT_WIDTH param, inc, async reset), instantiated twice for rd_count and wr_count.
- The array and the read register stay in the top.

Test Plan:
- Reset then idle -> d_out=0, addr_err=0, rd_count=0, wr_count=0. Reset asserted mid-read -> d_out=0 immediately.
- Preload addr 5 = 64'hDEADBEEF_00000001; read addr 5 -> d_out=64'hDEADBEEF_00000001 exactly one cycle after the sampling edge; rd_count=1; preload not counted.
- Write addr 3 = 64'h1234 at cycle N; read addr 3 at cycle N+1 -> d_out=64'h1234 at N+2; d_out unchanged during the write cycle; wr_count=1.
- Two-cycle load pattern (mem_en high 2 cycles at addr 7, then addr 9) -> d_out shows [7] then [9]; rd_count=2. With mem_en low afterwards, d_out holds [9].
- Read addr 32'h0000_0100 (out of range, DEPTH_LOG2=8) -> d_out=0, addr_err=1 sticky; a following write to 32'h0001_0000 leaves the array unchanged and counters unchanged.
- Same-cycle preload and core write to addr 2 (preload 64'hAA, core 64'hBB) -> array[2]=64'hAA. Separately, rd_count forced near all-ones -> saturates at 16'hFFFF.
